// File: rtl/jb_fft_pkg.sv
// Shared types and helpers for the FFT bit-reversed result reader.
package jb_fft_pkg;

    localparam int unsigned LOG2_W = 4;

    typedef enum logic [1:0] {
        SZ_128     = 2'd0,
        SZ_256     = 2'd1,
        SZ_512     = 2'd2,
        SZ_ILLEGAL = 2'd3
    } fft_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // log2 of the frame length for a size code; 0 for the illegal code
    function automatic logic [LOG2_W-1:0] size_to_log2n(input logic [1:0] sz);
        logic [LOG2_W-1:0] r;
        case (sz)
            SZ_128:  r = LOG2_W'(7);
            SZ_256:  r = LOG2_W'(8);
            SZ_512:  r = LOG2_W'(9);
            default: r = LOG2_W'(0);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jb_fft_skid_fifo.sv
// Two-entry output FIFO; the reader guarantees it is never pushed when full
// and never popped when empty.
module jb_fft_skid_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy; simultaneous push and pop both apply
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/jb_fft_bitrev_rd.sv
// Reads an FFT result buffer in bit-reversed index order and streams the
// samples out through a two-entry FIFO with a valid/ready handshake.
module jb_fft_bitrev_rd
    import jb_fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clk_en,
    input  logic                  start,
    input  logic [1:0]            fft_size,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = '1;

    rd_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] n, n_nxt;
    logic [LOG2_W-1:0]     log2n, log2n_nxt;
    logic                  busy_nxt, done_nxt, err_nxt;
    logic                  inflight, inflight_last;

    logic [LOG2_W-1:0]     shamt;
    logic [ADDR_WIDTH-1:0] n_max;
    logic [ADDR_WIDTH-1:0] n_rev;
    logic                  n_is_last;

    logic                  pop;
    logic [1:0]            fifo_count;
    logic [1:0]            occ_eff;
    logic [ENTRY_W-1:0]    fifo_head;

    // Frame length mask and bit reversal of n over log2(N) bits
    always_comb begin
        shamt = LOG2_W'(ADDR_WIDTH) - log2n;
        n_max = ADDR_MASK >> shamt;
        n_rev = '0;
        for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
            n_rev[i] = n[int'(ADDR_WIDTH) - 1 - i];
        end
        rd_addr   = n_rev >> shamt;
        n_is_last = (n == n_max);
    end

    // Read gating: the entry popped this cycle frees its slot now, which is
    // what lets a steady m_ready sustain one sample per clock
    always_comb begin
        pop     = m_valid & m_ready;
        occ_eff = fifo_count - {1'b0, pop};
        rd_en   = (state == ST_RUN) && clk_en && ((occ_eff + {1'b0, inflight}) < 2'd2);
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        log2n_nxt = log2n;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (fft_size == SZ_ILLEGAL) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                        n_nxt     = '0;
                        log2n_nxt = size_to_log2n(fft_size);
                    end
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    if (n_is_last) begin
                        state_nxt = ST_DRAIN;
                        n_nxt     = '0;
                    end else begin
                        n_nxt = n + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head[DATA_WIDTH]) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, counter and status registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            n             <= '0;
            log2n         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            n             <= n_nxt;
            log2n         <= log2n_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
            inflight      <= rd_en;
            inflight_last <= rd_en & n_is_last;
        end
    end

    jb_fft_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_data ({inflight_last, rd_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_head[DATA_WIDTH-1:0];
    assign m_last  = m_valid & fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_jb_fft_bitrev_rd.sv
// Bench for the bit-reversed FFT result reader: a buffer responder, a
// frame-level reference model and a per-cycle compare process.
module tb_jb_fft_bitrev_rd;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clk_en = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    fft_size = 2'd0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jb_fft_bitrev_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .clk_en   (clk_en),
        .start    (start),
        .fft_size (fft_size),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Buffer contents are a unique word per address
    function automatic logic [DW-1:0] buf_word(input int a);
        return 32'hB17E_0000 ^ (32'(a) << 20) ^ 32'(a);
    endfunction

    function automatic int bitrev(input int k, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Buffer responder: data is valid the cycle after the read strobe
    always @(posedge clk) rd_data <= rd_en ? buf_word(int'(rd_addr)) : 32'hDEAD_BEEF;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model state
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int            addr_q[$];
    int            addr_log[$];
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic          exp_err  = 1'b0;
    int            beats = 0;
    int            frames_done = 0;
    int            issued = 0;
    int            accepted = 0;
    int            first_valid_cyc = -1;
    int            last_acc_cyc = -1;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    logic          acc, acc_last;
    beat_t         mon_b;
    int            mon_nn, mon_lg;

    // Compare process: all outputs sampled on the falling edge
    always @(negedge clk) begin
        if (resetn) begin
            if (done) frames_done++;
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            check("err", 64'(err), 64'(exp_err));
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rd_en) begin
                check("rd_en_needs_clk_en", 64'(clk_en), 64'd1);
                if (addr_q.size() == 0) check("rd_en_unexpected", 64'(rd_en), 64'd0);
                else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
                addr_log.push_back(int'(rd_addr));
                issued++;
            end
            if (hold) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(hold_d));
                check("hold_last", 64'(m_last), 64'(hold_l));
            end
            acc      = m_valid && m_ready;
            acc_last = 1'b0;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(m_valid), 64'd0);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("m_data", 64'(m_data), 64'(mon_b.d));
                    check("m_last", 64'(m_last), 64'(mon_b.l));
                    acc_last = mon_b.l;
                end
                beats++;
                accepted++;
                if (acc_last) last_acc_cyc = cyc;
            end
            check("occupancy_bound", 64'((issued - accepted) <= 2), 64'd1);
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            exp_done = acc && acc_last;
            exp_err  = !exp_busy && start && (fft_size == 2'd3);
            if (exp_busy) begin
                exp_busy = !(acc && acc_last);
            end else if (start && fft_size != 2'd3) begin
                exp_busy = 1'b1;
                mon_lg   = 7 + int'(fft_size);
                mon_nn   = 1 << mon_lg;
                for (int k = 0; k < mon_nn; k++) begin
                    addr_q.push_back(bitrev(k, mon_lg));
                    mon_b.d = buf_word(bitrev(k, mon_lg));
                    mon_b.l = (k == mon_nn - 1);
                    exp_q.push_back(mon_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] sz);
        start    = 1'b1;
        fft_size = sz;
        tick();
        start = 1'b0;
    endtask

    // rmode 0: m_ready=1, 1: random; cmode 0: clk_en=1, 1: toggling
    task automatic wait_frame(input int rmode, input int cmode, input int restart_beat);
        int f0;
        int c;
        f0 = frames_done;
        c  = 0;
        while (frames_done == f0 && c < 4000) begin
            m_ready = (rmode == 0) ? 1'b1 : 1'($urandom & 1);
            clk_en  = (cmode == 0) ? 1'b1 : ~clk_en;
            start   = (restart_beat > 0 && beats == restart_beat) ? 1'b1 : 1'b0;
            tick();
            c++;
        end
        start = 1'b0;
        check("frame_timeout", 64'(frames_done > f0), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_last"}, 64'(m_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int c0;
        int iss0;
        int c;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Size 128, full throughput
        clk_en = 1'b1;
        m_ready = 1'b1;
        beats = 0;
        addr_log.delete();
        first_valid_cyc = -1;
        c0 = cyc;
        pulse_start(2'd0);
        wait_frame(0, 0, 0);
        check("n128_beats", 64'(beats), 64'd128);
        check("n128_addr0", 64'(addr_log[0]), 64'd0);
        check("n128_addr1", 64'(addr_log[1]), 64'd64);
        check("n128_addr2", 64'(addr_log[2]), 64'd32);
        check("n128_addr3", 64'(addr_log[3]), 64'd96);
        check("n128_addr4", 64'(addr_log[4]), 64'd16);
        check("n128_addr127", 64'(addr_log[127]), 64'd127);
        check("n128_first_valid_lat", 64'(first_valid_cyc - c0), 64'd3);
        check("n128_throughput", 64'(last_acc_cyc - first_valid_cyc), 64'd127);
        tick();

        // Size 512, random back-pressure
        clk_en = 1'b1;
        beats = 0;
        pulse_start(2'd2);
        wait_frame(1, 0, 0);
        check("n512_beats", 64'(beats), 64'd512);
        check("n512_model_empty", 64'(exp_q.size()), 64'd0);
        m_ready = 1'b1;
        tick();

        // Size 256, clk_en toggling
        clk_en = 1'b1;
        beats = 0;
        pulse_start(2'd1);
        wait_frame(0, 1, 0);
        check("n256_beats", 64'(beats), 64'd256);
        check("n256_addr_empty", 64'(addr_q.size()), 64'd0);
        clk_en = 1'b1;
        tick();

        // Illegal size
        iss0 = issued;
        pulse_start(2'd3);
        check("illegal_err", 64'(err), 64'd1);
        check("illegal_busy", 64'(busy), 64'd0);
        tick();
        check("illegal_err_clear", 64'(err), 64'd0);
        repeat (5) tick();
        check("illegal_no_read", 64'(issued), 64'(iss0));

        // Start re-asserted mid-frame
        beats = 0;
        pulse_start(2'd0);
        wait_frame(0, 0, 10);
        check("restart_beats", 64'(beats), 64'd128);
        tick();

        // Reset mid-frame
        beats = 0;
        pulse_start(2'd0);
        c = 0;
        while (beats < 50 && c < 500) begin
            tick();
            c++;
        end
        check("reset_mid_reached", 64'(beats), 64'd50);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        addr_q.delete();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        hold     = 1'b0;
        issued   = 0;
        accepted = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        beats = 0;
        addr_log.delete();
        pulse_start(2'd0);
        wait_frame(0, 0, 0);
        check("post_reset_addr0", 64'(addr_log[0]), 64'd0);
        check("post_reset_beats", 64'(beats), 64'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
